// File: rtl/hls_fp16_to_fp32_conv_pipe.sv
// Two-stage fp16 -> fp32 widening converter with valid/ready handshakes on both sides.
// Every fp16 code maps exactly onto fp32. S1 classifies and normalizes; S2 packs the fp32 word.
module hls_fp16_to_fp32_conv_pipe #(
  parameter int NAN_QUIET = 1
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        chn_a_vld,
  output logic        chn_a_rdy,
  input  logic [15:0] chn_a_pd,
  output logic        chn_o_vld,
  input  logic        chn_o_rdy,
  output logic [31:0] chn_o_pd,
  output logic        idle
);

  // Returns the index of the most significant set bit of a 10-bit fraction.
  function automatic logic [3:0] lod10(input logic [9:0] f);
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < 10; i++) begin
      if (f[i]) p = 4'(i);
    end
    return p;
  endfunction

  // Drops the leading one at index p and left-aligns the bits below it.
  function automatic logic [9:0] norm_man(input logic [9:0] f, input logic [3:0] p);
    logic [19:0] t;
    t = {10'b0, f} << (4'd10 - p);
    return t[9:0];
  endfunction

  logic        vld_p1, vld_p1_d;
  logic        sign_p1, sign_p1_d;
  logic        nan_p1, nan_p1_d;
  logic [7:0]  exp_p1, exp_p1_d;
  logic [9:0]  man_p1, man_p1_d;
  logic        vld_p2, vld_p2_d;
  logic [31:0] pd_p2, pd_p2_d;

  logic        s2_adv;
  logic        a_acc;
  logic [4:0]  exp_a;
  logic [9:0]  frac_a;
  logic [3:0]  lead_a;
  logic        nan_c;
  logic [7:0]  exp_c;
  logic [9:0]  man_c;
  logic [22:0] quiet_p1;

  always_comb begin
    s2_adv    = !vld_p2 || chn_o_rdy;
    chn_a_rdy = !vld_p1 || s2_adv;
    a_acc     = chn_a_vld && chn_a_rdy;

    // ---- stage 1: classify, leading-one detect, normalize ----
    exp_a  = chn_a_pd[14:10];
    frac_a = chn_a_pd[9:0];
    lead_a = lod10(frac_a);
    nan_c  = 1'b0;
    exp_c  = 8'd0;
    man_c  = 10'd0;
    if (exp_a == 5'd31) begin
      exp_c = 8'hFF;
      man_c = frac_a;
      nan_c = (frac_a != 10'd0);
    end else if (exp_a != 5'd0) begin
      exp_c = {3'b0, exp_a} + 8'd112;
      man_c = frac_a;
    end else if (frac_a != 10'd0) begin
      exp_c = {4'b0, lead_a} + 8'd103;
      man_c = norm_man(frac_a, lead_a);
    end

    vld_p1_d  = chn_a_rdy ? chn_a_vld : vld_p1;
    sign_p1_d = a_acc ? chn_a_pd[15] : sign_p1;
    nan_p1_d  = a_acc ? nan_c : nan_p1;
    exp_p1_d  = a_acc ? exp_c : exp_p1;
    man_p1_d  = a_acc ? man_c : man_p1;

    // ---- stage 2: assemble fp32 word ----
    quiet_p1 = {(nan_p1 && (NAN_QUIET != 0)), 22'b0};
    vld_p2_d = s2_adv ? vld_p1 : vld_p2;
    pd_p2_d  = (s2_adv && vld_p1) ? {sign_p1, exp_p1, ({man_p1, 13'b0} | quiet_p1)} : pd_p2;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      nan_p1  <= 1'b0;
      exp_p1  <= 8'd0;
      man_p1  <= 10'd0;
      vld_p2  <= 1'b0;
      pd_p2   <= 32'd0;
    end else begin
      vld_p1  <= vld_p1_d;
      sign_p1 <= sign_p1_d;
      nan_p1  <= nan_p1_d;
      exp_p1  <= exp_p1_d;
      man_p1  <= man_p1_d;
      vld_p2  <= vld_p2_d;
      pd_p2   <= pd_p2_d;
    end
  end

  assign chn_o_vld = vld_p2;
  assign chn_o_pd  = pd_p2;
  assign idle      = !vld_p1 && !vld_p2;

endmodule

// File: tb/tb_hls_fp16_to_fp32_conv_pipe.sv
// Scoreboard bench for hls_fp16_to_fp32_conv_pipe: a stimulus process pushes expected fp32
// words at each input accept, a monitor pops and compares at each output transfer.
module tb_hls_fp16_to_fp32_conv_pipe;

  localparam int NQ = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chn_a_vld = 1'b0;
  logic        chn_a_rdy;
  logic [15:0] chn_a_pd = 16'h0;
  logic        chn_o_vld;
  logic        chn_o_rdy = 1'b0;
  logic [31:0] chn_o_pd;
  logic        idle;

  hls_fp16_to_fp32_conv_pipe #(.NAN_QUIET(NQ)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .chn_a_vld(chn_a_vld),
    .chn_a_rdy(chn_a_rdy),
    .chn_a_pd(chn_a_pd),
    .chn_o_vld(chn_o_vld),
    .chn_o_rdy(chn_o_rdy),
    .chn_o_pd(chn_o_pd),
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pd;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_n  = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference: value of the fp16 code as a real number, re-encoded as fp32 through fp64 fields.
  function automatic logic [31:0] ref_conv(input logic [15:0] h);
    logic        s;
    int          e;
    logic [9:0]  f;
    real         v;
    logic [63:0] b;
    logic [10:0] e64;
    s = h[15];
    e = int'(h[14:10]);
    f = h[9:0];
    if (e == 31)
      return {s, 8'hFF, (f == 10'd0) ? 23'd0 : ({f, 13'b0} | ((NQ != 0) ? 23'h400000 : 23'h0))};
    if (e == 0 && f == 10'd0) return {s, 31'b0};
    if (e == 0) v = real'(f) * (2.0 ** (-24));
    else        v = (1024.0 + real'(f)) * (2.0 ** (e - 25));
    b   = $realtobits(v);
    e64 = b[62:52];
    return {s, 8'(e64 - 11'd896), b[51:29]};
  endfunction

  // One cycle of stimulus; inputs change only on the falling edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic o,
                     input bit use_e, input logic [31:0] e, input bit lat, output logic acc);
    exp_t x;
    @(negedge clk);
    chn_a_vld = v;
    chn_a_pd  = d;
    chn_o_rdy = o;
    #1;
    acc = v && chn_a_rdy && !rst;
    if (acc) begin
      x.pd  = use_e ? e : ref_conv(d);
      x.cyc = cyc_n;
      x.lat = lat;
      q.push_back(x);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [31:0] e, input bit lat);
    logic acc;
    int   n;
    n = 0;
    do begin
      cyc(1'b1, d, 1'b1, 1'b1, e, lat, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((q.size() != 0 || !idle) && n < 100) begin
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor: pop and compare on each output transfer, and check hold-under-stall.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pd    = 32'h0;
  always begin
    exp_t x;
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", {31'b0, chn_o_vld}, 32'd1);
        chk("hold_pd", chn_o_pd, prev_pd);
      end
      if (chn_o_vld && chn_o_rdy) begin
        if (q.size() == 0) begin
          chk("unexpected_output", chn_o_pd, 32'hxxxxxxxx);
        end else begin
          x = q.pop_front();
          chk("out_pd", chn_o_pd, x.pd);
          if (x.lat) chk("latency", 32'(cyc_n - x.cyc), 32'd2);
        end
      end
      prev_stall = chn_o_vld && !chn_o_rdy;
      prev_pd    = chn_o_pd;
    end
  end

  initial begin
    logic        acc;
    logic [15:0] code;
    int          idx;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_o_vld", {31'b0, chn_o_vld}, 32'd0);
    chk("rst_o_pd", chn_o_pd, 32'd0);
    chk("rst_idle", {31'b0, idle}, 32'd1);
    chk("rst_a_rdy", {31'b0, chn_a_rdy}, 32'd1);
    rst = 1'b0;

    // Streaming with known results and fixed latency
    send(16'h3C00, 32'h3F800000, 1'b1);
    send(16'h8000, 32'h80000000, 1'b1);
    send(16'h7C00, 32'h7F800000, 1'b1);
    send(16'hFC00, 32'hFF800000, 1'b1);
    drain();

    // Subnormals and NaNs
    send(16'h0001, 32'h33800000, 1'b1);
    send(16'h03FF, 32'h387FC000, 1'b1);
    send(16'h8200, 32'hB8000000, 1'b1);
    send(16'h7C01, (NQ != 0) ? 32'h7FC02000 : 32'h7F802000, 1'b1);
    send(16'h7E00, 32'h7FC00000, 1'b1);
    drain();

    // Backpressure: output stalled for five cycles with input always valid
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 16'h4000 + 16'(k), 1'b0, 1'b0, 32'h0, 1'b0, acc);
      chk("bp_a_rdy", {31'b0, chn_a_rdy}, (k < 2) ? 32'd1 : 32'd0);
    end
    drain();

    // Reset with both stages full
    cyc(1'b1, 16'h3C00, 1'b0, 1'b0, 32'h0, 1'b0, acc);
    cyc(1'b1, 16'h4000, 1'b0, 1'b0, 32'h0, 1'b0, acc);
    @(negedge clk);
    rst       = 1'b1;
    chn_a_vld = 1'b1;
    chn_o_rdy = 1'b0;
    #1;
    chk("rstmid_a_rdy", {31'b0, chn_a_rdy}, 32'd0);
    @(posedge clk);
    #1;
    q.delete();
    chk("rstmid_o_vld", {31'b0, chn_o_vld}, 32'd0);
    chk("rstmid_o_pd", chn_o_pd, 32'd0);
    chk("rstmid_idle", {31'b0, idle}, 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    chn_a_vld = 1'b0;
    send(16'hC500, 32'hC0A00000, 1'b1);
    drain();

    // Full sweep of all codes in permuted order with light random handshaking
    idx = 0;
    while (idx < 65536) begin
      code = 16'(idx * 40503 + 7);
      cyc(($urandom % 16) != 0, code, ($urandom % 16) != 0, 1'b0, 32'h0, 1'b0, acc);
      if (acc) idx++;
    end
    drain();

    // Heavy random handshaking on random codes
    idx = 0;
    while (idx < 2000) begin
      code = 16'($urandom);
      cyc(($urandom % 2) != 0, code, ($urandom % 2) != 0, 1'b0, 32'h0, 1'b0, acc);
      if (acc) idx++;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
